// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, runtime baud divisor, parity mode
// and stop-bit count; frame configuration is captured when each word is popped.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx_serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic [2:0]                    state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        count;

  logic [2:0]           state;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           mode_q;
  logic                 two_q;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;

  logic                 push;
  logic                 pop;
  logic                 tick;
  logic                 last_stop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // Handshake: a word transfers on any rising edge where tx_valid && tx_ready;
  // tx_ready reflects fullness only, so a same-cycle pop never raises it.
  assign tx_ready   = (count != LW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign tick       = (baud_cnt == div_q);
  assign last_stop  = (state == STOP) && tick && (stop_idx || !two_q);
  assign pop        = (count != '0) && ((state == IDLE) || last_stop);

  assign busy       = (state != IDLE);
  assign frame_done = last_stop;
  assign fifo_level = count;
  assign state_dbg  = state;

  always_comb begin
    head_par = 1'b1;
    case (parity_mode)
      2'b01:   head_par = ^head;
      2'b10:   head_par = ~^head;
      default: head_par = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_serial <= 1'b1;
      baud_cnt  <= '0;
      div_q     <= '0;
      mode_q    <= 2'b00;
      two_q     <= 1'b0;
      shreg     <= '0;
      par_q     <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
    end else begin
      if (state != IDLE) baud_cnt <= tick ? '0 : baud_cnt + DIV_WIDTH'(1);

      case (state)
        IDLE: tx_serial <= 1'b1;
        START: if (tick) begin
          state     <= DATA;
          tx_serial <= shreg[0];
          shreg     <= shreg >> 1;
          bit_idx   <= '0;
        end
        DATA: if (tick) begin
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            if (mode_q != 2'b00) begin
              state     <= PARITY;
              tx_serial <= par_q;
            end else begin
              state     <= STOP;
              tx_serial <= 1'b1;
              stop_idx  <= 1'b0;
            end
          end else begin
            bit_idx   <= bit_idx + BW'(1);
            tx_serial <= shreg[0];
            shreg     <= shreg >> 1;
          end
        end
        PARITY: if (tick) begin
          state     <= STOP;
          tx_serial <= 1'b1;
          stop_idx  <= 1'b0;
        end
        STOP: if (tick) begin
          if (last_stop) state <= IDLE;
          else           stop_idx <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
        end
      endcase

      // A pop (from IDLE or the final stop tick) overrides the transitions
      // above and starts the next frame with freshly captured configuration.
      if (pop) begin
        state     <= START;
        tx_serial <= 1'b0;
        baud_cnt  <= '0;
        div_q     <= baud_div;
        mode_q    <= parity_mode;
        two_q     <= two_stop;
        shreg     <= head;
        par_q     <= head_par;
      end
    end
  end

endmodule
